// File: rtl/pipe_front.sv
// Fetch/decode front end: PC register, F/D and D/E pipeline registers,
// stall-driven bubble insertion and a stall statistics monitor.
module pipe_front #(
    parameter logic [31:0] PC_RESET    = 32'h0000_3000,
    parameter int          STALL_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [31:0] F_Instr,
    input  logic        D_Jump,
    input  logic [31:0] D_Target,
    input  logic [31:0] D_RD1,
    input  logic [31:0] D_RD2,
    input  logic [31:0] D_EXT,
    output logic [31:0] F_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic [31:0] E_Instr,
    output logic [31:0] E_PC,
    output logic [31:0] E_RD1,
    output logic [31:0] E_RD2,
    output logic [31:0] E_EXT,
    output logic [31:0] Stall_cnt,
    output logic        Stall_err
);

    localparam int RUN_MAX = STALL_LIMIT + 1;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    logic [RUN_W-1:0] run_cnt;

    // Redirects take effect without flushing F/D, so the fetched instruction
    // behind a jump survives as its delay slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            F_PC    <= PC_RESET;
            D_Instr <= '0;
            D_PC    <= '0;
        end else if (!Stall) begin
            F_PC    <= D_Jump ? D_Target : F_PC + 32'd4;
            D_Instr <= F_Instr;
            D_PC    <= F_PC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_Instr <= '0;
            E_PC    <= '0;
            E_RD1   <= '0;
            E_RD2   <= '0;
            E_EXT   <= '0;
        end else if (Stall) begin
            E_Instr <= '0;
            E_PC    <= D_PC;
            E_RD1   <= '0;
            E_RD2   <= '0;
            E_EXT   <= '0;
        end else begin
            E_Instr <= D_Instr;
            E_PC    <= D_PC;
            E_RD1   <= D_RD1;
            E_RD2   <= D_RD2;
            E_EXT   <= D_EXT;
        end
    end

    // Run counter stops one past the limit so an overlong stall is flagged once
    // and the counter can never wrap back into the legal range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stall_cnt <= '0;
            run_cnt   <= '0;
            Stall_err <= 1'b0;
        end else if (Stall) begin
            if (Stall_cnt != 32'hFFFF_FFFF) begin
                Stall_cnt <= Stall_cnt + 32'd1;
            end
            if (run_cnt != RUN_W'(RUN_MAX)) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
            if (run_cnt >= RUN_W'(STALL_LIMIT)) begin
                Stall_err <= 1'b1;
            end
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_front.sv
// Randomized self-checking bench for pipe_front: a stage-token reference model
// compared every cycle, plus directed literal scenarios.
module tb_pipe_front;

    localparam logic [31:0] PC_RESET    = 32'h0000_3000;
    localparam int          STALL_LIMIT = 2;
    localparam logic [31:0] LW          = 32'h8C08_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] f_instr;
    logic        d_jump;
    logic [31:0] d_target, d_rd1, d_rd2, d_ext;
    logic [31:0] F_PC, D_Instr, D_PC, E_Instr, E_PC, E_RD1, E_RD2, E_EXT, Stall_cnt;
    logic        Stall_err;

    int checks = 0;
    int errors = 0;

    pipe_front #(.PC_RESET(PC_RESET), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .reset(reset), .Stall(stall), .F_Instr(f_instr),
        .D_Jump(d_jump), .D_Target(d_target), .D_RD1(d_rd1), .D_RD2(d_rd2), .D_EXT(d_ext),
        .F_PC(F_PC), .D_Instr(D_Instr), .D_PC(D_PC), .E_Instr(E_Instr), .E_PC(E_PC),
        .E_RD1(E_RD1), .E_RD2(E_RD2), .E_EXT(E_EXT), .Stall_cnt(Stall_cnt), .Stall_err(Stall_err)
    );

    always #5 clk = ~clk;

    // Reference model: each stage holds a token; stall history is an unbounded run length.
    typedef struct {
        logic [31:0] instr, pc, rd1, rd2, ext;
    } token_t;

    logic [31:0] m_pc;
    token_t      m_dec, m_exe;
    longint      m_cnt;
    int          m_run;
    bit          m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc  <= PC_RESET;
            m_dec <= '{0, 0, 0, 0, 0};
            m_exe <= '{0, 0, 0, 0, 0};
            m_cnt <= 0;
            m_run <= 0;
            m_err <= 0;
        end else if (stall) begin
            m_exe <= '{0, m_dec.pc, 0, 0, 0};
            m_cnt <= (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
            m_run <= m_run + 1;
            if (m_run + 1 > STALL_LIMIT) m_err <= 1;
        end else begin
            m_pc  <= d_jump ? d_target : 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
            m_dec <= '{f_instr, m_pc, 0, 0, 0};
            m_exe <= '{m_dec.instr, m_dec.pc, d_rd1, d_rd2, d_ext};
            m_run <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("F_PC", F_PC, m_pc);
        checkOutput("D_Instr", D_Instr, m_dec.instr);
        checkOutput("D_PC", D_PC, m_dec.pc);
        checkOutput("E_Instr", E_Instr, m_exe.instr);
        checkOutput("E_PC", E_PC, m_exe.pc);
        checkOutput("E_RD1", E_RD1, m_exe.rd1);
        checkOutput("E_RD2", E_RD2, m_exe.rd2);
        checkOutput("E_EXT", E_EXT, m_exe.ext);
        checkOutput("Stall_cnt", Stall_cnt, m_cnt[31:0]);
        checkOutput("Stall_err", {31'b0, Stall_err}, {31'b0, m_err});
    end

    task automatic applyStimulus(input logic s, input logic [31:0] instr,
                                 input logic j, input logic [31:0] tgt);
        stall    = s;
        f_instr  = instr;
        d_jump   = j;
        d_target = tgt;
        d_rd1    = $urandom;
        d_rd2    = $urandom;
        d_ext    = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int burst;
        burst = 0;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        checkOutput("reset F_PC", F_PC, 32'h0000_3000);
        checkOutput("reset E_Instr", E_Instr, 32'h0);
        checkOutput("reset Stall_cnt", Stall_cnt, 32'h0);

        @(negedge clk);
        #1 reset = 1'b1;
        applyStimulus(0, 32'h3404_0001, 0, 0);
        tick();
        tick();
        checkOutput("basic F_PC", F_PC, 32'h0000_3008);
        checkOutput("basic E_Instr", E_Instr, 32'h3404_0001);
        checkOutput("basic E_PC", E_PC, 32'h0000_3000);

        applyStimulus(0, 32'h2408_0005, 0, 0);
        tick();
        applyStimulus(0, LW, 0, 0);
        tick();
        checkOutput("pre-stall F_PC", F_PC, 32'h0000_3010);
        applyStimulus(1, 32'h1111_1111, 0, 0);
        tick();
        checkOutput("stall F_PC", F_PC, 32'h0000_3010);
        checkOutput("stall D_Instr", D_Instr, LW);
        checkOutput("stall E_Instr", E_Instr, 32'h0);
        checkOutput("stall E_PC", E_PC, 32'h0000_300C);
        checkOutput("stall Stall_cnt", Stall_cnt, 32'd1);

        applyStimulus(0, 32'h2222_2222, 0, 0);
        repeat (4) tick();
        checkOutput("pre-jump F_PC", F_PC, 32'h0000_3020);
        applyStimulus(0, 32'h3333_3333, 1, 32'h0000_3100);
        tick();
        checkOutput("jump F_PC", F_PC, 32'h0000_3100);
        checkOutput("delay slot D_PC", D_PC, 32'h0000_3020);

        applyStimulus(1, 32'h4444_4444, 1, 32'h0000_3200);
        tick();
        checkOutput("stalled jump F_PC", F_PC, 32'h0000_3100);
        applyStimulus(0, 32'h4444_4444, 1, 32'h0000_3200);
        tick();
        checkOutput("released jump F_PC", F_PC, 32'h0000_3200);

        applyStimulus(1, 32'h5555_5555, 0, 0);
        tick();
        checkOutput("run1 Stall_err", {31'b0, Stall_err}, 32'd0);
        tick();
        checkOutput("run2 Stall_err", {31'b0, Stall_err}, 32'd0);
        tick();
        checkOutput("run3 Stall_err", {31'b0, Stall_err}, 32'd1);
        checkOutput("run3 Stall_cnt", Stall_cnt, 32'd5);
        applyStimulus(0, 32'h5555_5555, 0, 0);
        tick();
        checkOutput("sticky Stall_err", {31'b0, Stall_err}, 32'd1);
        applyStimulus(0, 32'h6666_6666, 1, 32'hFFFF_FFFC);
        tick();
        checkOutput("top F_PC", F_PC, 32'hFFFF_FFFC);
        applyStimulus(0, 32'h6666_6666, 0, 0);
        tick();
        checkOutput("wrap F_PC", F_PC, 32'h0000_0000);

        applyStimulus(1, 32'h7777_7777, 1, 32'h0000_3300);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("async F_PC", F_PC, 32'h0000_3000);
        checkOutput("async D_PC", D_PC, 32'h0);
        checkOutput("async Stall_cnt", Stall_cnt, 32'h0);
        checkOutput("async Stall_err", {31'b0, Stall_err}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        applyStimulus(0, 32'h8888_8888, 0, 0);
        tick();
        checkOutput("post-reset F_PC", F_PC, 32'h0000_3004);
        checkOutput("post-reset D_PC", D_PC, 32'h0000_3000);

        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 5);
            applyStimulus((burst > 0) || ($urandom_range(0, 9) < 3), $urandom,
                          ($urandom_range(0, 3) == 0), $urandom);
            if (burst > 0) burst--;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_front.md
PIPE_FRONT -- requirements
Module: pipe_front

Interface
REQ-001 Parameter: PC_RESET, default 32'h0000_3000, fetch address loaded on reset.
REQ-002 Parameter: STALL_LIMIT, default 2, maximum legal run of consecutive Stall cycles.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 Port: Stall  input  1  freeze request from the hazard-detection unit.
REQ-006 Port: F_Instr  input  32  instruction returned by instruction memory for F_PC.
REQ-007 Port: D_Jump  input  1  D-stage instruction redirects fetch (taken branch, j, jal, jr, jalr).
REQ-008 Port: D_Target  input  32  redirect address computed in D.
REQ-009 Port: D_RD1, D_RD2, D_EXT  input  32 each  forwarded rs value, forwarded rt value, extended immediate.
REQ-010 Port: F_PC  output  32  current fetch address.
REQ-011 Port: D_Instr, D_PC  output  32 each  F/D register contents.
REQ-012 Port: E_Instr, E_PC, E_RD1, E_RD2, E_EXT  output  32 each  D/E register contents.
REQ-013 Port: Stall_cnt  output  32  total stalled cycles since reset.
REQ-014 Port: Stall_err  output  1  sticky flag: Stall run exceeded STALL_LIMIT.

Function
REQ-015 The block SHALL update F_PC, the F/D register and the D/E register on every rising clk edge while reset=1.
REQ-016 With Stall=0 the block SHALL load F_PC with D_Target when D_Jump=1, else F_PC+4 modulo 2^32.
REQ-017 With Stall=0 the block SHALL load D_Instr<=F_Instr and D_PC<=F_PC.
REQ-018 With Stall=0 the block SHALL load E_Instr<=D_Instr, E_PC<=D_PC, E_RD1<=D_RD1, E_RD2<=D_RD2, E_EXT<=D_EXT.
REQ-019 With Stall=1 the block SHALL hold F_PC, D_Instr and D_PC unchanged and SHALL ignore D_Jump.
REQ-020 With Stall=1 the block SHALL insert a bubble: E_Instr, E_RD1, E_RD2 and E_EXT <= 0; E_PC <= D_PC.
REQ-021 The block SHALL NOT flush the F/D register on redirect; the instruction after a jump executes as the delay slot.
REQ-022 D_Target SHALL be used unmodified; no alignment check, no masking.
REQ-023 Latency: instruction fetched at F_PC SHALL appear on D_Instr one unstalled edge later, and on E_Instr two unstalled edges later.
REQ-024 Stall_cnt SHALL increment by 1 on each edge sampling Stall=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-025 An internal run counter SHALL count consecutive edges sampling Stall=1; it SHALL clear on any edge sampling Stall=0.
REQ-026 Stall_err SHALL set on the edge on which the run counter would reach STALL_LIMIT+1, and SHALL then stay 1 until reset.
REQ-027 The run counter SHALL saturate at STALL_LIMIT+1 and SHALL NOT wrap.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-029 While reset=0: F_PC=PC_RESET; D_Instr, D_PC, all E_* registers, Stall_cnt, the run counter and Stall_err = 0.
REQ-030 Asserting reset mid-stall or mid-redirect SHALL discard the pending update; the first edge after release SHALL behave as REQ-016..018 from the reset state.
REQ-031 Reset assertion SHALL take effect without a clock edge.

Verification
REQ-032 Reset released, Stall=0, D_Jump=0, F_Instr=32'h3404_0001, two edges -> F_PC=32'h0000_3008, E_Instr=32'h3404_0001, E_PC=32'h0000_3000.
REQ-033 D_Instr=lw, F_PC=32'h0000_3010, Stall=1 for one edge -> F_PC and D_Instr unchanged, E_Instr=0, E_PC=D_PC, Stall_cnt=1.
REQ-034 Stall=0, D_Jump=1, D_Target=32'h0000_3100, F_PC=32'h0000_3020 -> F_PC=32'h0000_3100, D_PC=32'h0000_3020 (delay slot kept).
REQ-035 Stall=1 with D_Jump=1, D_Target=32'h0000_3200 -> F_PC holds; on the next edge with Stall=0 and D_Jump=1, F_PC=32'h0000_3200.
REQ-036 Stall=1 for 3 consecutive edges (STALL_LIMIT=2) -> Stall_err=0 after edges 1-2, 1 after edge 3, still 1 after Stall=0; F_PC=32'hFFFF_FFFC with Stall=0 -> F_PC=0.
REQ-037 reset=0 pulsed between edges during a stall -> outputs reach reset values immediately, with no clock edge.
